// File: rtl/eco32f_hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// eco32f_hazard_scoreboard_pkg : instruction classes and EX tag for the scoreboard
// Revision: 1.0
// ============================================================================
package eco32f_hazard_scoreboard_pkg;

  localparam int NUM_REGS = 32;

  typedef enum logic [1:0] {
    CLASS_ALU  = 2'd0,
    CLASS_LOAD = 2'd1,
    CLASS_MUL  = 2'd2,
    CLASS_DIV  = 2'd3
  } eco32f_class_e;

  typedef struct packed {
    logic [4:0]    rd;
    eco32f_class_e cls;
  } ex_tag_t;

  // r0 is hard-wired, so it never maps to a tracked bit
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [4:0] addr);
    logic [NUM_REGS-1:0] v;
    v = '0;
    if (addr != 5'd0) v[addr] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/eco32f_hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// eco32f_hazard_scoreboard_if : decode-stage request / bubble interface
// Revision: 1.0
// ============================================================================
interface eco32f_hazard_scoreboard_if;
  import eco32f_hazard_scoreboard_pkg::*;

  logic          id_stall;
  logic          id_flush;
  logic [4:0]    id_rf_x_addr;
  logic [4:0]    id_rf_y_addr;
  logic          id_rf_x_used;
  logic          id_rf_y_used;
  logic [4:0]    id_rf_r_addr;
  logic          id_rf_r_we;
  eco32f_class_e id_class;
  logic          div_done;
  logic          id_bubble;
  logic          div_busy;
  logic [31:0]   pending;

  modport master (
    output id_stall, id_flush, id_rf_x_addr, id_rf_y_addr, id_rf_x_used,
           id_rf_y_used, id_rf_r_addr, id_rf_r_we, id_class, div_done,
    input  id_bubble, div_busy, pending
  );

  modport slave (
    input  id_stall, id_flush, id_rf_x_addr, id_rf_y_addr, id_rf_x_used,
           id_rf_y_used, id_rf_r_addr, id_rf_r_we, id_class, div_done,
    output id_bubble, div_busy, pending
  );

endinterface
`default_nettype wire

// File: rtl/eco32f_hazard_scoreboard_sb_counter.sv
`default_nettype none
// ============================================================================
// eco32f_sb_counter : saturating down-counter with load-max and clear
// Revision: 1.0
// ============================================================================
module eco32f_sb_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             busy_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] dec;

  always_comb begin
    dec   = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = dec;
      // a newer writer never shortens an older, longer pending result
      if (load_i && (load_val_i > dec)) cnt_d = load_val_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign busy_o = (cnt_q != '0);

endmodule
`default_nettype wire

// File: rtl/eco32f_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// eco32f_hazard_scoreboard : per-register pending counters driving the ID bubble
// Revision: 1.0
// ============================================================================
module eco32f_hazard_scoreboard
  import eco32f_hazard_scoreboard_pkg::*;
#(
  parameter int LOAD_LAT = 2,
  parameter int MUL_LAT  = 3,
  parameter int CNT_W    = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  eco32f_hazard_scoreboard_if.slave sb
);

  logic [NUM_REGS-1:1] cnt_nz;
  logic [NUM_REGS-1:1] cnt_clr;
  logic [NUM_REGS-1:1] cnt_load;
  logic [NUM_REGS-1:0] reg_busy;
  logic                cnt_en;
  logic                flush_clr;
  logic                issue;
  logic                x_busy;
  logic                y_busy;
  logic                bubble;
  logic [CNT_W-1:0]    lat_val;

  logic                div_pend_q, div_pend_d;
  logic [4:0]          div_rd_q, div_rd_d;
  ex_tag_t             ex_tag_q, ex_tag_d;
  logic                ex_tag_valid_q, ex_tag_valid_d;

  assign reg_busy = {cnt_nz, 1'b0};

  // div_done bypasses the divider destination in the cycle it arrives
  always_comb begin
    x_busy = (sb.id_rf_x_addr != 5'd0) &&
             (reg_busy[sb.id_rf_x_addr] ||
              (div_pend_q && !sb.div_done && (div_rd_q == sb.id_rf_x_addr)));
    y_busy = (sb.id_rf_y_addr != 5'd0) &&
             (reg_busy[sb.id_rf_y_addr] ||
              (div_pend_q && !sb.div_done && (div_rd_q == sb.id_rf_y_addr)));
    bubble = (sb.id_rf_x_used && x_busy) ||
             (sb.id_rf_y_used && y_busy) ||
             ((sb.id_class == CLASS_DIV) && div_pend_q);
    issue  = !sb.id_stall && !sb.id_flush && !bubble &&
             sb.id_rf_r_we && (sb.id_rf_r_addr != 5'd0);
  end

  always_comb begin
    cnt_en    = !sb.id_stall || sb.id_flush;
    flush_clr = sb.id_flush && ex_tag_valid_q;
    case (sb.id_class)
      CLASS_LOAD: lat_val = CNT_W'(LOAD_LAT - 1);
      CLASS_MUL:  lat_val = CNT_W'(MUL_LAT - 1);
      default:    lat_val = '0;
    endcase
    cnt_clr  = '0;
    cnt_load = '0;
    for (int n = 1; n < NUM_REGS; n++) begin
      cnt_clr[n]  = flush_clr && (ex_tag_q.rd == 5'(n));
      cnt_load[n] = issue && (sb.id_rf_r_addr == 5'(n));
    end
  end

  generate
    for (genvar n = 1; n < NUM_REGS; n++) begin : g_cnt
      eco32f_sb_counter #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .en_i       (cnt_en),
        .clr_i      (cnt_clr[n]),
        .load_i     (cnt_load[n]),
        .load_val_i (lat_val),
        .busy_o     (cnt_nz[n])
      );
    end
  endgenerate

  // The divider runs independently of the pipeline, so its completion is
  // honoured even in a stalled cycle; otherwise the pulse would be lost.
  always_comb begin
    div_pend_d     = div_pend_q;
    div_rd_d       = div_rd_q;
    ex_tag_d       = ex_tag_q;
    ex_tag_valid_d = ex_tag_valid_q;
    if (sb.div_done) div_pend_d = 1'b0;
    if (sb.id_flush) begin
      ex_tag_valid_d = 1'b0;
      if (ex_tag_valid_q && (ex_tag_q.cls == CLASS_DIV)) div_pend_d = 1'b0;
    end else if (!sb.id_stall) begin
      ex_tag_valid_d = issue;
      if (issue) begin
        ex_tag_d.rd  = sb.id_rf_r_addr;
        ex_tag_d.cls = sb.id_class;
        if (sb.id_class == CLASS_DIV) begin
          div_pend_d = 1'b1;
          div_rd_d   = sb.id_rf_r_addr;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_pend_q     <= 1'b0;
      div_rd_q       <= 5'd0;
      ex_tag_q       <= '0;
      ex_tag_valid_q <= 1'b0;
    end else begin
      div_pend_q     <= div_pend_d;
      div_rd_q       <= div_rd_d;
      ex_tag_q       <= ex_tag_d;
      ex_tag_valid_q <= ex_tag_valid_d;
    end
  end

  assign sb.id_bubble = bubble;
  assign sb.div_busy  = div_pend_q;
  assign sb.pending   = reg_busy | (div_pend_q ? reg_onehot(div_rd_q) : '0);

endmodule
`default_nettype wire

// File: tb/tb_eco32f_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// tb_eco32f_hazard_scoreboard : cycle-table and reset sequence for the scoreboard
// Revision: 1.0
// ============================================================================
module tb_eco32f_hazard_scoreboard;
  import eco32f_hazard_scoreboard_pkg::*;

  typedef struct {
    logic          stall;
    logic          flush;
    logic [4:0]    x;
    logic          xu;
    logic [4:0]    y;
    logic          yu;
    logic [4:0]    r;
    logic          we;
    eco32f_class_e cls;
    logic          done;
    logic          e_bub;
    logic          e_busy;
    logic [31:0]   e_pend;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  eco32f_hazard_scoreboard_if sb_if();

  eco32f_hazard_scoreboard #(
    .LOAD_LAT (2),
    .MUL_LAT  (3),
    .CNT_W    (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
  );

  function automatic logic [31:0] rb(input int n);
    logic [31:0] v;
    v = 32'h1 << n;
    return v;
  endfunction

  task automatic add(input int st, input int fl, input int x, input int xu,
                     input int y, input int yu, input int r, input int we,
                     input eco32f_class_e c, input int dd, input int eb,
                     input int ebz, input logic [31:0] ep);
    vec_t v;
    v.stall = 1'(st);  v.flush = 1'(fl);
    v.x     = 5'(x);   v.xu    = 1'(xu);
    v.y     = 5'(y);   v.yu    = 1'(yu);
    v.r     = 5'(r);   v.we    = 1'(we);
    v.cls   = c;       v.done  = 1'(dd);
    v.e_bub = 1'(eb);  v.e_busy = 1'(ebz);
    v.e_pend = ep;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    sb_if.id_stall     = v.stall;
    sb_if.id_flush     = v.flush;
    sb_if.id_rf_x_addr = v.x;
    sb_if.id_rf_x_used = v.xu;
    sb_if.id_rf_y_addr = v.y;
    sb_if.id_rf_y_used = v.yu;
    sb_if.id_rf_r_addr = v.r;
    sb_if.id_rf_r_we   = v.we;
    sb_if.id_class     = v.cls;
    sb_if.div_done     = v.done;
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %08h want %08h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input vec_t v);
    chk("id_bubble", idx, 32'(sb_if.id_bubble), 32'(v.e_bub));
    chk("div_busy",  idx, 32'(sb_if.div_busy),  32'(v.e_busy));
    chk("pending",   idx, sb_if.pending,        v.e_pend);
  endtask

  vec_t idle_v;
  vec_t tmp;

  initial begin
    idle_v = '{stall: 1'b0, flush: 1'b0, x: 5'd0, xu: 1'b0, y: 5'd0, yu: 1'b0,
               r: 5'd0, we: 1'b0, cls: CLASS_ALU, done: 1'b0, e_bub: 1'b0,
               e_busy: 1'b0, e_pend: 32'h0};
    drive(idle_v);

    //   st fl  x xu  y yu  r we class       dd  bub busy pend
    add(0, 0,  0, 0, 0, 0,  0, 0, CLASS_ALU,  0,  0, 0, 32'h0);
    add(0, 0,  0, 0, 0, 0,  5, 1, CLASS_LOAD, 0,  0, 0, 32'h0);
    add(0, 0,  5, 1, 0, 0, 10, 1, CLASS_ALU,  0,  1, 0, rb(5));
    add(0, 0,  5, 1, 0, 0, 10, 1, CLASS_ALU,  0,  0, 0, 32'h0);
    add(0, 0,  0, 0, 0, 0,  7, 1, CLASS_MUL,  0,  0, 0, 32'h0);
    add(0, 0,  0, 0, 7, 1, 11, 1, CLASS_ALU,  0,  1, 0, rb(7));
    add(1, 0,  0, 0, 7, 1, 11, 1, CLASS_ALU,  0,  1, 0, rb(7));
    add(1, 0,  0, 0, 7, 1, 11, 1, CLASS_ALU,  0,  1, 0, rb(7));
    add(1, 0,  0, 0, 7, 1, 11, 1, CLASS_ALU,  0,  1, 0, rb(7));
    add(0, 0,  0, 0, 7, 1, 11, 1, CLASS_ALU,  0,  1, 0, rb(7));
    add(0, 0,  0, 0, 7, 1, 11, 1, CLASS_ALU,  0,  0, 0, 32'h0);
    add(0, 0,  0, 0, 0, 0,  9, 1, CLASS_DIV,  0,  0, 0, 32'h0);
    add(0, 0,  9, 1, 0, 0, 12, 1, CLASS_ALU,  0,  1, 1, rb(9));
    add(0, 0,  0, 0, 0, 0, 13, 1, CLASS_DIV,  0,  1, 1, rb(9));
    add(0, 0,  9, 1, 0, 0, 12, 1, CLASS_ALU,  1,  0, 1, rb(9));
    add(0, 0,  0, 0, 0, 0,  0, 0, CLASS_ALU,  0,  0, 0, 32'h0);
    add(0, 0,  0, 0, 0, 0,  3, 1, CLASS_LOAD, 0,  0, 0, 32'h0);
    add(0, 1,  3, 1, 0, 0, 14, 1, CLASS_ALU,  0,  1, 0, rb(3));
    add(0, 0,  3, 1, 0, 0, 14, 1, CLASS_ALU,  0,  0, 0, 32'h0);
    add(0, 0,  0, 0, 0, 0,  3, 1, CLASS_MUL,  0,  0, 0, 32'h0);
    add(0, 1,  0, 0, 0, 0,  0, 0, CLASS_ALU,  0,  0, 0, rb(3));
    add(0, 0,  3, 1, 0, 0, 14, 1, CLASS_ALU,  0,  0, 0, 32'h0);
    add(0, 0,  0, 0, 0, 0,  9, 1, CLASS_DIV,  0,  0, 0, 32'h0);
    add(0, 1,  0, 0, 0, 0,  0, 0, CLASS_ALU,  0,  0, 1, rb(9));
    add(0, 0,  9, 1, 0, 0, 15, 1, CLASS_ALU,  0,  0, 0, 32'h0);
    add(0, 0,  0, 0, 0, 0,  0, 1, CLASS_LOAD, 0,  0, 0, 32'h0);
    add(0, 0,  0, 1, 0, 1, 16, 1, CLASS_ALU,  0,  0, 0, 32'h0);
    add(0, 0,  0, 0, 0, 0,  4, 1, CLASS_MUL,  0,  0, 0, 32'h0);
    add(0, 0,  0, 0, 0, 0,  4, 1, CLASS_LOAD, 0,  0, 0, rb(4));
    add(0, 0,  4, 1, 0, 0, 17, 1, CLASS_ALU,  0,  1, 0, rb(4));
    add(0, 0,  4, 1, 0, 0, 17, 1, CLASS_ALU,  0,  0, 0, 32'h0);
    add(0, 0,  0, 0, 0, 0,  4, 1, CLASS_MUL,  0,  0, 0, 32'h0);
    add(0, 0,  0, 0, 0, 0,  4, 1, CLASS_ALU,  0,  0, 0, rb(4));
    add(0, 0,  4, 1, 0, 0, 17, 1, CLASS_ALU,  0,  1, 0, rb(4));
    add(0, 0,  4, 1, 0, 0, 17, 1, CLASS_ALU,  0,  0, 0, 32'h0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk_all(i, vecs[i]);
    end

    // Asynchronous reset with a divide and a mul outstanding
    tmp = idle_v; tmp.r = 5'd9; tmp.we = 1'b1; tmp.cls = CLASS_DIV;
    @(negedge clk); drive(tmp);
    tmp = idle_v; tmp.r = 5'd6; tmp.we = 1'b1; tmp.cls = CLASS_MUL;
    @(negedge clk); drive(tmp);
    @(negedge clk); drive(idle_v);
    #1;
    chk("pre_rst_pending", 100, sb_if.pending, rb(6) | rb(9));
    chk("pre_rst_busy",    100, 32'(sb_if.div_busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_pending", 101, sb_if.pending, 32'h0);
    chk("rst_busy",    101, 32'(sb_if.div_busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    tmp = idle_v; tmp.x = 5'd6; tmp.xu = 1'b1; tmp.y = 5'd9; tmp.yu = 1'b1;
    tmp.r = 5'd5; tmp.we = 1'b1; tmp.cls = CLASS_LOAD;
    @(negedge clk); drive(tmp);
    #1;
    chk("post_rst_bubble", 102, 32'(sb_if.id_bubble), 32'h0);
    tmp = idle_v; tmp.x = 5'd5; tmp.xu = 1'b1; tmp.r = 5'd8; tmp.we = 1'b1;
    @(negedge clk); drive(tmp);
    #1;
    chk("post_rst_load_bubble", 103, 32'(sb_if.id_bubble), 32'h1);
    chk("post_rst_pending",     103, sb_if.pending, rb(5));

    @(negedge clk); drive(idle_v);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/eco32f_hazard_scoreboard.md
Name: eco32f_hazard_scoreboard

Overview:
- Parametrised per-register scoreboard for the eco32f decode stage.
- Replaces the fixed "load/mul in EX or MEM" bubble equation with per-register pending counters. Load and multiply latencies are configurable, and an iterative divider of variable latency is supported.
- Sits beside the decode stage: the decode stage presents each candidate instruction's sources and destination, and the block returns the bubble request. Results become usable in the first cycle a register's counter reads zero.

Parameters:
- LOAD_LAT, 2, cycles from issue until a load result is usable by a following issue (1..7).
- MUL_LAT, 3, cycles from issue until a mul result is usable (1..7).
- CNT_W, 3, counter width; must hold max(LOAD_LAT, MUL_LAT).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- id_stall  in  1  pipeline stall; freezes counters, no issue recorded
- id_flush  in  1  kills the instruction in ID and the one issued last cycle (in EX)
- id_rf_x_addr  in  5  source x
- id_rf_y_addr  in  5  source y
- id_rf_x_used  in  1  source x is read
- id_rf_y_used  in  1  source y is read
- id_rf_r_addr  in  5  destination
- id_rf_r_we  in  1  destination written
- id_class  in  2  0 = single-cycle, 1 = load, 2 = mul, 3 = div
- div_done  in  1  divider result usable this cycle
- id_bubble  out  1  hazard; decode must insert a no-op
- div_busy  out  1  a divide is outstanding
- pending  out  32  bit n set when register n has a non-zero counter or an outstanding div

Behaviour:
- Reset: all counters 0, div_pend = 0, div_rd = 0, ex_tag_valid = 0. Outputs therefore reset to id_bubble = 0, div_busy = 0, pending = 0.
- Register 0 is never tracked. Writes to r0 are ignored, and a source address of 0 never hazards.
- Hazard (combinational): id_bubble = (x_used & busy(x)) | (y_used & busy(y)) | (id_class == 3 & div_pend).
  - busy(n) = cnt[n] != 0, or (div_pend & div_rd == n & !div_done).
  - div_done bypasses in the same cycle.
- Issue condition: issue = !id_stall & !id_flush & !id_bubble & id_rf_r_we & r_addr != 0.
- On issue:
  - Load sets cnt[rd] = max(cnt[rd] - 1, LOAD_LAT - 1).
  - Mul sets cnt[rd] = max(cnt[rd] - 1, MUL_LAT - 1).
  - Single-cycle leaves cnt[rd] at max(cnt[rd] - 1, 0); full forwarding exists for this class.
  - Div sets div_pend = 1 and div_rd = rd.
  - ex_tag records {rd, class}, and ex_tag_valid is set.
- Every cycle with !id_stall: all non-issuing counters decrement, saturating at 0. ex_tag_valid takes the value of issue.
- id_stall high: counters, div state and ex_tag hold. id_bubble is still computed.
- div_done: clears div_pend. If div_done coincides with a new div issue, the new div wins (div_pend stays 1, div_rd is updated).
- id_flush (stall ignored):
  - If ex_tag_valid, the entry of ex_tag.rd is cleared: its counter goes to 0, and div_pend is cleared if ex_tag is a div.
  - No issue is recorded. Other counters decrement normally.
  - ex_tag_valid goes to 0.
- Reset asserted mid-operation clears all state asynchronously. The first cycle after deassert behaves as a fresh start.
- pending is registered-state derived, with no div_done bypass.

Decomposition:
- Add to eco32f.vh: `ECO32F_CLASS_ALU/LOAD/MUL/DIV 2-bit encodings.
- Sub-module eco32f_sb_counter holds one saturating down-counter with load-max and clear. It is instantiated 31 times in a generate loop for r1..r31.

Test Plan:
- Load r5 issued with LOAD_LAT = 2, next insn reads r5 -> id_bubble = 1 for 1 cycle; issue succeeds on the 2nd attempt; pending[5] falls after 1 cycle.
- Mul r7 with MUL_LAT = 3, dependent reader of r7 via y -> bubble for 2 cycles. With id_stall high for 3 cycles in between, bubble persists and counters freeze.
- Div r9, then a reader of r9 -> bubble until div_done pulses. The reader issues in the div_done cycle. A second div while div_busy -> bubble.
- Load r3 issued, id_flush next cycle -> cnt[3] cleared, pending[3] = 0, a following reader of r3 sees no bubble.
- Load r0 and a reader of r0 -> no bubble, pending = 0. WAW: mul r4 then load r4 -> cnt[4] = max(1, 1) = 1.
- Assert rst while div pending and cnt[6] = 2 -> pending = 0 and div_busy = 0 immediately (asynchronous).
